// File: rtl/ntt_stream_pkg.sv
// Shared types and default geometry for the NTT memory streamer.
package ntt_stream_pkg;

    localparam int unsigned DEF_D_WIDTH = 32;
    localparam int unsigned DEF_BN      = 16;
    localparam int unsigned DEF_MA      = 64;

    localparam int unsigned BANK_W = $clog2(DEF_BN);
    localparam int unsigned ROW_W  = $clog2(DEF_MA);
    localparam int unsigned DEGREE = DEF_BN * DEF_MA;

    typedef logic [DEF_D_WIDTH-1:0] coef_t;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        UNLOAD
    } state_t;

endpackage

// File: rtl/ntt_stream_fifo.sv
// Small synchronous FIFO with occupancy count; buffers UNLOAD read returns.
module ntt_stream_fifo #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned W     = 32,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1),
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             push,
    input  logic [W-1:0]     wdata,
    input  logic             pop,
    output logic [W-1:0]     rdata,
    output logic [CNT_W-1:0] count
);

    logic [W-1:0]     mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push, do_pop;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        do_pop  = pop && (count_q != '0);
        do_push = push && ((count_q != CNT_W'(DEPTH)) || do_pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= wdata;
                wr_ptr_q        <= next_ptr(wr_ptr_q);
            end
            if (do_pop) rd_ptr_q <= next_ptr(rd_ptr_q);
            count_q <= count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    assign rdata = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/ntt_mem_streamer.sv
// Streams coefficients into (LOAD) and out of (UNLOAD) the banked polynomial memory,
// coefficient n living at bank n%BN, row n/BN.
module ntt_mem_streamer
    import ntt_stream_pkg::*;
#(
    parameter int unsigned D_WIDTH = DEF_D_WIDTH,
    parameter int unsigned BN      = DEF_BN,
    parameter int unsigned MA      = DEF_MA,
    parameter int unsigned RD_LAT  = 1,
    localparam int unsigned BANK_BITS = $clog2(BN),
    localparam int unsigned ROW_BITS  = $clog2(MA)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [D_WIDTH-1:0]   modulus,
    input  logic                 start,
    input  logic                 mode,
    input  logic                 abort,
    output logic                 busy,
    output logic                 done,
    output logic                 range_err,
    input  logic                 s_valid,
    output logic                 s_ready,
    input  logic [D_WIDTH-1:0]   s_data,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic [D_WIDTH-1:0]   m_data,
    output logic                 m_last,
    output logic                 mem_we,
    output logic [BANK_BITS-1:0] mem_bank,
    output logic [ROW_BITS-1:0]  mem_row,
    output logic [D_WIDTH-1:0]   mem_wdata,
    output logic                 mem_re,
    input  logic [D_WIDTH-1:0]   mem_rdata
);

    localparam int unsigned N_COEF = BN * MA;
    localparam int unsigned IDX_W  = $clog2(N_COEF);
    localparam int unsigned DEPTH  = RD_LAT + 1;
    localparam int unsigned CNT_W  = $clog2(DEPTH + 1);
    localparam int unsigned OCC_W  = CNT_W + 1;

    state_t               state_q, state_d;
    logic [BANK_BITS-1:0] bank_cnt_q, bank_cnt_d;
    logic [ROW_BITS-1:0]  row_cnt_q, row_cnt_d;
    logic [IDX_W-1:0]     out_cnt_q, out_cnt_d;
    logic                 range_err_q, range_err_d;
    logic                 done_q, done_d;
    logic                 issue_done_q, issue_done_d;
    logic [RD_LAT-1:0]    rd_pipe_q, rd_pipe_d;

    logic [D_WIDTH-1:0]   fifo_rdata;
    logic [CNT_W-1:0]     fifo_count;
    logic [OCC_W-1:0]     inflight;
    logic                 credit_ok, load_hs, pop, at_last, advance, over;

    always_comb begin
        inflight = '0;
        for (int i = 0; i < RD_LAT; i++) inflight = inflight + OCC_W'(rd_pipe_q[i]);
    end

    always_comb begin
        over      = s_data >= modulus;
        s_ready   = (state_q == LOAD) && !abort;
        load_hs   = s_valid && s_ready;
        mem_we    = load_hs;
        mem_wdata = load_hs ? (over ? s_data - modulus : s_data) : '0;

        m_valid = (state_q == UNLOAD) && (fifo_count != '0) && !abort;
        m_data  = m_valid ? fifo_rdata : '0;
        m_last  = m_valid && (out_cnt_q == IDX_W'(N_COEF - 1));
        pop     = m_valid && m_ready;

        // A slot freed by this cycle's pop may be re-credited at once to sustain one beat/cycle.
        credit_ok = (inflight + OCC_W'(fifo_count)) < (OCC_W'(DEPTH) + OCC_W'(pop));
        mem_re    = (state_q == UNLOAD) && !abort && !issue_done_q && credit_ok;

        mem_bank = bank_cnt_q;
        mem_row  = row_cnt_q;
        at_last  = (bank_cnt_q == BANK_BITS'(BN - 1)) && (row_cnt_q == ROW_BITS'(MA - 1));
        advance  = load_hs || mem_re;
    end

    always_comb begin
        rd_pipe_d = '0;
        if (!abort) begin
            rd_pipe_d[0] = mem_re;
            for (int i = 1; i < RD_LAT; i++) rd_pipe_d[i] = rd_pipe_q[i-1];
        end
    end

    always_comb begin
        state_d      = state_q;
        bank_cnt_d   = bank_cnt_q;
        row_cnt_d    = row_cnt_q;
        out_cnt_d    = out_cnt_q;
        range_err_d  = range_err_q;
        issue_done_d = issue_done_q;
        done_d       = 1'b0;

        if (advance) begin
            bank_cnt_d = bank_cnt_q + 1'b1;
            if (bank_cnt_q == BANK_BITS'(BN - 1)) row_cnt_d = row_cnt_q + 1'b1;
        end

        if (abort) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_d      = mode ? UNLOAD : LOAD;
                        bank_cnt_d   = '0;
                        row_cnt_d    = '0;
                        out_cnt_d    = '0;
                        range_err_d  = 1'b0;
                        issue_done_d = 1'b0;
                    end
                end
                LOAD: begin
                    if (load_hs) begin
                        if (over) range_err_d = 1'b1;
                        if (at_last) begin
                            done_d  = 1'b1;
                            state_d = IDLE;
                        end
                    end
                end
                UNLOAD: begin
                    if (mem_re && at_last) issue_done_d = 1'b1;
                    if (pop) begin
                        out_cnt_d = out_cnt_q + 1'b1;
                        if (m_last) begin
                            done_d  = 1'b1;
                            state_d = IDLE;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            bank_cnt_q   <= '0;
            row_cnt_q    <= '0;
            out_cnt_q    <= '0;
            range_err_q  <= 1'b0;
            done_q       <= 1'b0;
            issue_done_q <= 1'b0;
            rd_pipe_q    <= '0;
        end else begin
            state_q      <= state_d;
            bank_cnt_q   <= bank_cnt_d;
            row_cnt_q    <= row_cnt_d;
            out_cnt_q    <= out_cnt_d;
            range_err_q  <= range_err_d;
            done_q       <= done_d;
            issue_done_q <= issue_done_d;
            rd_pipe_q    <= rd_pipe_d;
        end
    end

    ntt_stream_fifo #(
        .DEPTH(DEPTH),
        .W    (D_WIDTH)
    ) u_fifo (
        .clk  (clk),
        .rst_n(rst_n),
        .flush(abort),
        .push (rd_pipe_q[RD_LAT-1]),
        .wdata(mem_rdata),
        .pop  (pop),
        .rdata(fifo_rdata),
        .count(fifo_count)
    );

    assign busy      = state_q != IDLE;
    assign done      = done_q;
    assign range_err = range_err_q;

endmodule

// File: tb/tb_ntt_mem_streamer.sv
// Scoreboard bench for ntt_mem_streamer: behavioural banked memory with RD_LAT=2,
// expected writes/beats queued by the stimulus and checked by a negedge monitor.
module tb_ntt_mem_streamer;
    import ntt_stream_pkg::*;

    localparam int unsigned RD_LAT = 2;
    localparam coef_t       MOD    = 32'd167772161;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    coef_t             modulus = MOD;
    logic              start = 1'b0, mode = 1'b0, abort = 1'b0;
    logic              busy, done, range_err;
    logic              s_valid = 1'b0, s_ready;
    coef_t             s_data = '0;
    logic              m_valid, m_ready = 1'b0, m_last;
    coef_t             m_data;
    logic              mem_we, mem_re;
    logic [BANK_W-1:0] mem_bank;
    logic [ROW_W-1:0]  mem_row;
    coef_t             mem_wdata, mem_rdata;

    ntt_mem_streamer #(
        .D_WIDTH(DEF_D_WIDTH),
        .BN     (DEF_BN),
        .MA     (DEF_MA),
        .RD_LAT (RD_LAT)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .modulus  (modulus),
        .start    (start),
        .mode     (mode),
        .abort    (abort),
        .busy     (busy),
        .done     (done),
        .range_err(range_err),
        .s_valid  (s_valid),
        .s_ready  (s_ready),
        .s_data   (s_data),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .m_data   (m_data),
        .m_last   (m_last),
        .mem_we   (mem_we),
        .mem_bank (mem_bank),
        .mem_row  (mem_row),
        .mem_wdata(mem_wdata),
        .mem_re   (mem_re),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    coef_t mem_arr [DEF_BN][DEF_MA];
    coef_t rd_s1 = '0, rd_s2 = '0;
    always @(posedge clk) begin
        if (mem_we) mem_arr[mem_bank][mem_row] <= mem_wdata;
        rd_s1 <= mem_re ? mem_arr[mem_bank][mem_row] : '0;
        rd_s2 <= rd_s1;
    end
    assign mem_rdata = rd_s2;

    typedef struct {
        logic [BANK_W-1:0] bank;
        logic [ROW_W-1:0]  row;
        coef_t             data;
    } wr_t;
    typedef struct {
        coef_t data;
        logic  last;
    } beat_t;

    wr_t   exp_wr[$];
    beat_t exp_beat[$];
    int    pass_cnt = 0, total_cnt = 0;
    int    cyc = 0;
    int    op_wr, op_beats, re_total, outst_max, done_seen;
    int    start_cyc, first_wr_cyc, last_wr_cyc, first_beat_cyc, last_beat_cyc, done_cyc;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    wr_t   mw;
    beat_t mb;
    int    outst;
    always @(negedge clk) begin
        if (rst_n && start && !busy && !abort) begin
            op_wr = 0; op_beats = 0; re_total = 0; outst_max = 0; done_seen = 0;
            start_cyc = cyc;
        end
        outst = re_total - op_beats;
        if (outst > outst_max) outst_max = outst;
        if (mem_we) begin
            chk("we_re_exclusive", mem_re, 0);
            chk("write_expected", exp_wr.size() != 0, 1);
            if (exp_wr.size() != 0) begin
                mw = exp_wr.pop_front();
                chk("wr_addr", {mem_bank, mem_row}, {mw.bank, mw.row});
                chk("wr_data", mem_wdata, mw.data);
            end
            if (op_wr == 0) first_wr_cyc = cyc;
            last_wr_cyc = cyc;
            op_wr++;
        end
        if (mem_re) re_total++;
        if (m_valid && m_ready) begin
            chk("beat_expected", exp_beat.size() != 0, 1);
            if (exp_beat.size() != 0) begin
                mb = exp_beat.pop_front();
                chk("beat_data", m_data, mb.data);
                chk("beat_last", m_last, mb.last);
            end
            if (op_beats == 0) first_beat_cyc = cyc;
            last_beat_cyc = cyc;
            op_beats++;
        end
        if (done) begin
            done_seen++;
            done_cyc = cyc;
        end
    end

    function automatic coef_t stim_val(input int variant, input int n);
        if (variant == 1) begin
            case (n)
                0:       return 32'd167772163;
                1:       return 32'hFFFF_FFFF;
                2:       return MOD;
                3:       return MOD - 1;
                default: return coef_t'(3 * n + 1);
            endcase
        end
        if (variant == 2) return coef_t'(5 * n + 2);
        return coef_t'(n);
    endfunction

    function automatic coef_t exp_val(input int variant, input int n);
        if (variant == 1) begin
            case (n)
                0:       return 32'd2;
                1:       return 32'hF5FF_FFFE;  // >= 2*modulus: single subtract only
                2:       return 32'd0;
                3:       return 32'h0A00_0000;
                default: return coef_t'(3 * n + 1);
            endcase
        end
        return stim_val(variant, n);
    endfunction

    task automatic chk_reset_outputs(input string name);
        chk({name, "_ctrl"}, {busy, done, range_err, s_ready, m_valid, m_last, mem_we, mem_re}, 0);
        chk({name, "_addr"}, {mem_bank, mem_row}, 0);
        chk({name, "_data"}, {mem_wdata, m_data}, 0);
    endtask

    task automatic wait_idle(input string name);
        int g = 0;
        while (busy && g < 5000) begin
            @(posedge clk); #1;
            g++;
        end
        @(negedge clk); #1;
        chk(name, busy, 0);
    endtask

    task automatic do_load(input int variant, input int stop_at);
        int n = 0, guard = 0, cnt;
        logic hs;
        wr_t e;
        cnt = (stop_at > 0) ? stop_at : DEGREE;
        for (int i = 0; i < cnt; i++) begin
            e.bank = BANK_W'(i % DEF_BN);
            e.row  = ROW_W'(i / DEF_BN);
            e.data = exp_val(variant, i);
            exp_wr.push_back(e);
        end
        @(posedge clk); #1;
        start = 1'b1; mode = 1'b0;
        @(posedge clk); #1;
        start = 1'b0; s_valid = 1'b1; s_data = stim_val(variant, 0);
        while (n < cnt && guard < 4000) begin
            @(negedge clk);
            hs = s_valid && s_ready;
            @(posedge clk); #1;
            if (hs) begin
                n++;
                if (n < cnt) s_data = stim_val(variant, n);
            end
            // A start (UNLOAD) while busy must be ignored.
            start = (variant == 0) && (n == 300);
            mode  = start;
            guard++;
        end
        start = 1'b0; mode = 1'b0; s_valid = 1'b0; s_data = '0;
        chk("load_accepted", n, cnt);
    endtask

    task automatic check_load_done(input string name);
        wait_idle({name, "_timeout"});
        chk({name, "_writes"}, op_wr, DEGREE);
        chk({name, "_queue_empty"}, exp_wr.size(), 0);
        chk({name, "_first_latency"}, first_wr_cyc - start_cyc, 1);
        chk({name, "_span"}, last_wr_cyc - first_wr_cyc, DEGREE - 1);
        chk({name, "_done_count"}, done_seen, 1);
        chk({name, "_done_cycle"}, done_cyc - last_wr_cyc, 1);
    endtask

    task automatic do_unload(input int variant, input bit rnd, input int abort_at);
        int guard = 0, cnt;
        beat_t b;
        cnt = (abort_at > 0) ? abort_at : DEGREE;
        for (int i = 0; i < cnt; i++) begin
            b.data = exp_val(variant, i);
            b.last = (i == DEGREE - 1);
            exp_beat.push_back(b);
        end
        @(posedge clk); #1;
        start = 1'b1; mode = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; mode = 1'b0;
        chk("range_err_cleared_by_start", range_err, 0);
        chk("busy_after_start", busy, 1);
        m_ready = rnd ? ($urandom_range(0, 99) < 30) : 1'b1;
        while (guard < 20000) begin
            @(posedge clk); #1;
            guard++;
            if (abort_at > 0 && op_beats == abort_at) break;
            if (!busy) break;
            m_ready = rnd ? ($urandom_range(0, 99) < 30) : 1'b1;
        end
        chk("unload_bounded", guard < 20000, 1);
        if (abort_at > 0) begin
            abort = 1'b1;
            @(posedge clk); #1;
            abort = 1'b0;
            @(negedge clk); #1;
            chk("abort_busy_low", busy, 0);
            chk("abort_m_valid_low", m_valid, 0);
            repeat (8) @(posedge clk);
            #1;
            chk("abort_no_done", done_seen, 0);
            chk("abort_beats", op_beats, abort_at);
            chk("abort_queue_empty", exp_beat.size(), 0);
            m_ready = 1'b0;
        end else begin
            m_ready = 1'b0;
            wait_idle("unload_timeout");
            chk("unload_beats", op_beats, DEGREE);
            chk("unload_queue_empty", exp_beat.size(), 0);
            chk("unload_done_count", done_seen, 1);
            chk("unload_done_cycle", done_cyc - last_beat_cyc, 1);
            chk("unload_outstanding_max", outst_max <= 3, 1);
            if (!rnd) begin
                chk("unload_first_latency", first_beat_cyc - start_cyc, 1 + RD_LAT + 1);
                chk("unload_no_gaps", last_beat_cyc - first_beat_cyc, DEGREE - 1);
            end
        end
    endtask

    initial begin
        #12;
        chk_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        do_load(0, 0);
        check_load_done("load_ramp");
        chk("load_ramp_range_err", range_err, 0);

        do_unload(0, 1'b0, 0);

        do_load(1, 0);
        check_load_done("load_reduce");
        chk("range_err_set", range_err, 1);
        repeat (5) @(posedge clk);
        #1;
        chk("range_err_sticky", range_err, 1);

        do_unload(1, 1'b1, 0);
        do_unload(1, 1'b0, 500);
        do_unload(1, 1'b0, 0);

        do_load(2, 200);
        rst_n = 1'b0; s_valid = 1'b1; s_data = 32'd99;
        #2;
        chk_reset_outputs("mid_reset");
        chk("mid_reset_writes", op_wr, 200);
        chk("mid_reset_queue_empty", exp_wr.size(), 0);
        @(negedge clk);
        s_valid = 1'b0; s_data = '0;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        do_load(2, 0);
        check_load_done("load_after_reset");
        do_unload(2, 1'b0, 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
